// File: rtl/conv_window_index_gen.sv
// Sliding-window (row, column) tap address generator for one tile of a tiled image.
// Emits one tap per accepted handshake, with window and window-row boundary flags.
module conv_window_index_gen #(
    parameter int TILE_W  = 6,
    parameter int TILE_H  = 6,
    parameter int TILES_X = 2,
    parameter int TILES_Y = 2,
    parameter int KERNEL  = 3,
    parameter int STRIDE  = 1,
    parameter int IDX_W   = 4,
    parameter int TSEL_W  = 2,
    localparam int TAP_W  = (KERNEL * KERNEL > 1) ? $clog2(KERNEL * KERNEL) : 1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [TSEL_W-1:0] tile_sel,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [IDX_W-1:0]  row_index,
    output logic [IDX_W-1:0]  column_index,
    output logic [TAP_W-1:0]  tap_index,
    output logic              last_tap,
    output logic              last_window_in_row,
    output logic              done,
    output logic              fsm_state
);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t state, state_next;

    logic [IDX_W-1:0] kr, kc, wr, wc, base_row, base_col;
    logic [IDX_W-1:0] kr_n, kc_n, wr_n, wc_n, base_row_n, base_col_n;
    logic             last_tap_q, last_win_q;
    logic             load, fire;
    logic             kc_end, kr_end, wc_end, wr_end, final_tap;

    // Handshake: a tap transfers on any clock edge where out_valid && out_ready;
    // while out_ready is low every output holds, and out_valid never drops mid-scan.

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (fire && final_tap) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_valid          = (state == SCAN);
        last_tap           = out_valid & last_tap_q;
        last_window_in_row = out_valid & last_win_q;
        fsm_state          = state;
    end

    always_comb begin
        load      = (state == IDLE) && start;
        fire      = (state == SCAN) && out_ready;
        kc_end    = (kc == IDX_W'(KERNEL - 1));
        kr_end    = (kr == IDX_W'(KERNEL - 1));
        wc_end    = (wc == IDX_W'(TILE_W - KERNEL));
        wr_end    = (wr == IDX_W'(TILE_H - KERNEL));
        final_tap = kc_end && kr_end && wc_end && wr_end;

        kr_n       = kr;
        kc_n       = kc;
        wr_n       = wr;
        wc_n       = wc;
        base_row_n = base_row;
        base_col_n = base_col;

        if (load) begin
            kr_n       = '0;
            kc_n       = '0;
            wr_n       = '0;
            wc_n       = '0;
            base_row_n = IDX_W'((32'(tile_sel) / TILES_X) * TILE_H);
            base_col_n = IDX_W'((32'(tile_sel) % TILES_X) * TILE_W);
        end else if (fire) begin
            if (final_tap) begin
                kr_n = '0;
                kc_n = '0;
                wr_n = '0;
                wc_n = '0;
            end else if (!kc_end) begin
                kc_n = kc + IDX_W'(1);
            end else begin
                kc_n = '0;
                if (!kr_end) begin
                    kr_n = kr + IDX_W'(1);
                end else begin
                    // Window finished: step the origin right, or wrap to the next window row.
                    kr_n = '0;
                    if (!wc_end) begin
                        wc_n = wc + IDX_W'(STRIDE);
                    end else begin
                        wc_n = '0;
                        wr_n = wr + IDX_W'(STRIDE);
                    end
                end
            end
        end
    end

    // Addresses and flags are registered from the next counter values so they
    // line up with the counters on the same edge.
    always_ff @(posedge clock) begin
        if (clear) begin
            kr           <= '0;
            kc           <= '0;
            wr           <= '0;
            wc           <= '0;
            base_row     <= '0;
            base_col     <= '0;
            row_index    <= '0;
            column_index <= '0;
            tap_index    <= '0;
            last_tap_q   <= 1'b0;
            last_win_q   <= 1'b0;
            done         <= 1'b0;
        end else begin
            kr           <= kr_n;
            kc           <= kc_n;
            wr           <= wr_n;
            wc           <= wc_n;
            base_row     <= base_row_n;
            base_col     <= base_col_n;
            row_index    <= base_row_n + wr_n + kr_n;
            column_index <= base_col_n + wc_n + kc_n;
            tap_index    <= TAP_W'(kr_n * KERNEL + kc_n);
            last_tap_q   <= (kr_n == IDX_W'(KERNEL - 1)) && (kc_n == IDX_W'(KERNEL - 1));
            last_win_q   <= (wc_n == IDX_W'(TILE_W - KERNEL));
            done         <= fire && final_tap;
        end
    end

endmodule
